// File: rtl/alu_ctl_pkg.sv
// alu_ctl_pkg: shared widths, opcode constants and controller state type.
package alu_ctl_pkg;
    localparam int DATA_W = 4;
    localparam int SEL_W  = 3;
    localparam logic [SEL_W-1:0] OP_ADD = 3'b000;
    localparam logic [SEL_W-1:0] OP_SUB = 3'b001;
    localparam logic [SEL_W-1:0] OP_AND = 3'b010;
    localparam logic [SEL_W-1:0] OP_OR  = 3'b011;
    localparam logic [SEL_W-1:0] OP_XOR = 3'b100;
    localparam logic [SEL_W-1:0] OP_NOT = 3'b101;
    localparam logic [SEL_W-1:0] OP_SHL = 3'b110;
    localparam logic [SEL_W-1:0] OP_SHR = 3'b111;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_4bit.sv
// alu_4bit: combinational 4-bit ALU with zero/carry/overflow flags.
module alu_4bit
    import alu_ctl_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [SEL_W-1:0]  alu_sel,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero,
    output logic              carry,
    output logic              overflow
);
    logic [DATA_W:0] sum, diff;
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    // carry on SUB is the borrow out
    always_comb begin
        alu_result = '0;
        carry      = 1'b0;
        overflow   = 1'b0;
        case (alu_sel)
            OP_ADD: begin
                {carry, alu_result} = sum;
                overflow = (a[3] == b[3]) && (sum[3] != a[3]);
            end
            OP_SUB: begin
                {carry, alu_result} = diff;
                overflow = (a[3] != b[3]) && (diff[3] != a[3]);
            end
            OP_AND: alu_result = a & b;
            OP_OR:  alu_result = a | b;
            OP_XOR: alu_result = a ^ b;
            OP_NOT: alu_result = ~a;
            OP_SHL: {carry, alu_result} = {a, 1'b0};
            default: {alu_result, carry} = {1'b0, a};
        endcase
    end
    assign zero = (alu_result == '0);
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr; one-hot grant plus index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx
);
    function automatic logic [ID_W-1:0] wrap(input int p);
        return ID_W'(p % NUM_REQ);
    endfunction
    // scan farthest-first so the closest valid requester to ptr overwrites last
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (en && req[wrap(int'(ptr) + k)]) begin
                gnt = '0;
                gnt[wrap(int'(ptr) + k)] = 1'b1;
                idx = wrap(int'(ptr) + k);
            end
        end
    end
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one ALU among NUM_REQ requesters,
// one op in flight, result returned over a valid/ready response channel.
module alu_share_ctrl
    import alu_ctl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    input  logic [SEL_W*NUM_REQ-1:0]  req_sel,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_zero,
    output logic                      rsp_carry,
    output logic                      rsp_overflow,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [SEL_W-1:0]          alu_sel,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic                      alu_zero,
    input  logic                      alu_carry,
    input  logic                      alu_overflow,
    output logic                      busy
);
    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d, id_q, id_d, rid_q, rid_d, gnt_idx;
    logic [DATA_W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;
    logic [NUM_REQ-1:0] gnt;

    // grants are suppressed while reset is asserted, not just after it lands
    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .en  (reset && state_q == IDLE),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        rid_d   = rid_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        res_d   = res_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (|gnt) begin
                a_d     = req_a[int'(gnt_idx)*DATA_W +: DATA_W];
                b_d     = req_b[int'(gnt_idx)*DATA_W +: DATA_W];
                sel_d   = req_sel[int'(gnt_idx)*SEL_W +: SEL_W];
                id_d    = gnt_idx;
                ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                rid_d   = id_q;
                res_d   = alu_result;
                zero_d  = alu_zero;
                carry_d = alu_carry;
                ovf_d   = alu_overflow;
                state_d = RESP;
            end
            RESP: state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            rid_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            rid_q   <= rid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign req_ready    = gnt;
    assign rsp_valid    = (state_q == RESP);
    assign busy         = (state_q != IDLE);
    assign rsp_id       = rid_q;
    assign rsp_result   = res_q;
    assign rsp_zero     = zero_q;
    assign rsp_carry    = carry_q;
    assign rsp_overflow = ovf_q;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_sel      = sel_q;
endmodule
